mmss_set_counter: RTL and testbench



---
 rtl/mmss_set_counter.sv | 94 +++++++++
 tb/tb_mmss_set_counter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mmss_set_counter.sv
// mmss_set_counter: settable mm:ss time base with synchronised, debounced set buttons
// clk_100MHZ, reset  : system clock, asynchronous active-high reset
// tick_1hz           : one-cycle enable per second
// btn_mode, btn_inc  : raw push-buttons (mode cycle, field increment)
// sec1/sec2/min1/min2: BCD time digits
// mode, edit_mask    : 00 RUN / 01 SET_MIN / 10 SET_SEC, digits currently being set
module mmss_set_counter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHZ,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec1,
  output logic [2:0] sec2,
  output logic [3:0] min1,
  output logic [2:0] min2,
  output logic [1:0] mode,
  output logic [3:0] edit_mask
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} state_t;
  state_t r_state, w_next;
  logic [1:0] w_raw, r_s0, r_s1, r_stable, r_press;
  logic [1:0][CW-1:0] r_cnt;
  logic [3:0] r_sec1, r_min1, r_edit;
  logic [2:0] r_sec2, r_min2;
  logic w_mode_ev, w_inc_ev, w_sec_inc, w_min_inc, w_sec_wrap;
  assign w_raw = {btn_mode, btn_inc};
  // Bit 1 is mode, bit 0 is inc; the counter accepts a new level after it has
  // differed from the stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_100MHZ or posedge reset)
    if (reset) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_stable <= '0;
      r_press <= '0;
      r_cnt <= '0;
    end else begin
      r_s0 <= w_raw;
      r_s1 <= r_s0;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_s1[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_s1[i];
          r_cnt[i] <= '0;
          r_press[i] <= r_s1[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  // A mode press discards a coincident inc press.
  assign w_mode_ev = r_press[1];
  assign w_inc_ev = r_press[0] & ~r_press[1];
  assign w_sec_wrap = (r_sec1 >= 4'd9) && (r_sec2 >= 3'd5);
  assign w_sec_inc = (r_state == RUN && tick_1hz) || (r_state == SET_SEC && w_inc_ev);
  assign w_min_inc = (r_state == RUN && tick_1hz && w_sec_wrap) || (r_state == SET_MIN && w_inc_ev);
  always_comb begin
    w_next = r_state;
    if (w_mode_ev) w_next = r_state == RUN ? SET_MIN : r_state == SET_MIN ? SET_SEC : RUN;
  end
  always_ff @(posedge clk_100MHZ or posedge reset)
    if (reset) begin
      r_state <= RUN;
      r_edit <= 4'b0000;
    end else begin
      r_state <= w_next;
      r_edit <= w_next == SET_MIN ? 4'b1100 : w_next == SET_SEC ? 4'b0011 : 4'b0000;
    end
  // Out-of-range values are treated as the terminal digit so they fold back to 0.
  always_ff @(posedge clk_100MHZ or posedge reset)
    if (reset) begin
      r_sec1 <= '0;
      r_sec2 <= '0;
      r_min1 <= '0;
      r_min2 <= '0;
    end else begin
      if (w_sec_inc) begin
        r_sec1 <= r_sec1 >= 4'd9 ? 4'd0 : r_sec1 + 4'd1;
        if (r_sec1 >= 4'd9) r_sec2 <= r_sec2 >= 3'd5 ? 3'd0 : r_sec2 + 3'd1;
      end
      if (w_min_inc) begin
        r_min1 <= r_min1 >= 4'd9 ? 4'd0 : r_min1 + 4'd1;
        if (r_min1 >= 4'd9) r_min2 <= r_min2 >= 3'd5 ? 3'd0 : r_min2 + 3'd1;
      end
    end
  assign sec1 = r_sec1;
  assign sec2 = r_sec2;
  assign min1 = r_min1;
  assign min2 = r_min2;
  assign mode = r_state;
  assign edit_mask = r_edit;
endmodule

// File: tb/tb_mmss_set_counter.sv
// tb_mmss_set_counter: directed self-checking bench for mmss_set_counter
module tb_mmss_set_counter;
  logic clk_100MHZ = 1'b0, reset = 1'b1, tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] sec1, min1, edit_mask;
  logic [2:0] sec2, min2;
  logic [1:0] mode;
  int n_chk = 0, n_err = 0;
  mmss_set_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_100MHZ(clk_100MHZ), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .mode(mode), .edit_mask(edit_mask)
  );
  always #5 clk_100MHZ = ~clk_100MHZ;
  function automatic logic [15:0] tv();
    return {1'b0, min2, min1, 1'b0, sec2, sec1};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100MHZ) tick_1hz = 1'b1;
      @(negedge clk_100MHZ) tick_1hz = 1'b0;
    end
  endtask
  task automatic press(input bit m, input bit c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100MHZ) begin btn_mode = m; btn_inc = c; end
      repeat (10) @(negedge clk_100MHZ);
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      repeat (10) @(negedge clk_100MHZ);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk_100MHZ);
    reset = 1'b0;
    chk("reset_time", tv(), 16'h0000);
    chk("reset_mode", 16'(mode), 16'h0);
    chk("reset_mask", 16'(edit_mask), 16'h0);
    tick(61);
    chk("run_61", tv(), 16'h0101);
    chk("run_61_mode", 16'(mode), 16'h0);
    chk("run_61_mask", 16'(edit_mask), 16'h0);
    press(1, 0, 1);
    chk("setmin_mode", 16'(mode), 16'h1);
    chk("setmin_mask", 16'(edit_mask), 16'hC);
    press(0, 1, 3);
    chk("setmin_inc3", tv(), 16'h0401);
    tick(10);
    chk("setmin_ticks", tv(), 16'h0401);
    press(0, 1, 55);
    chk("setmin_59", tv(), 16'h5901);
    press(0, 1, 1);
    chk("setmin_wrap", tv(), 16'h0001);
    press(0, 1, 59);
    chk("setmin_back59", tv(), 16'h5901);
    press(1, 0, 1);
    chk("setsec_mode", 16'(mode), 16'h2);
    chk("setsec_mask", 16'(edit_mask), 16'h3);
    press(0, 1, 58);
    chk("setsec_59", tv(), 16'h5959);
    press(0, 1, 1);
    chk("setsec_wrap", tv(), 16'h5900);
    press(0, 1, 58);
    tick(2);
    chk("setsec_58_ticks", tv(), 16'h5958);
    press(1, 0, 1);
    chk("run_mode", 16'(mode), 16'h0);
    chk("run_mask", 16'(edit_mask), 16'h0);
    tick(1);
    chk("run_5959", tv(), 16'h5959);
    tick(1);
    chk("run_rollover", tv(), 16'h0000);
    press(0, 1, 1);
    chk("run_inc_ignored", tv(), 16'h0000);
    press(1, 0, 1);
    @(negedge clk_100MHZ) btn_inc = 1'b1;
    repeat (3) @(negedge clk_100MHZ);
    btn_inc = 1'b0;
    repeat (15) @(negedge clk_100MHZ);
    chk("glitch", tv(), 16'h0000);
    @(negedge clk_100MHZ) btn_inc = 1'b1;
    repeat (6) @(negedge clk_100MHZ);
    chk("hold_e6", tv(), 16'h0000);
    @(negedge clk_100MHZ);
    chk("hold_e7", tv(), 16'h0100);
    repeat (13) @(negedge clk_100MHZ);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk_100MHZ);
    chk("hold_once", tv(), 16'h0100);
    press(1, 1, 1);
    chk("simul_mode", 16'(mode), 16'h2);
    chk("simul_time", tv(), 16'h0100);
    @(negedge clk_100MHZ) btn_mode = 1'b1;
    repeat (3) @(negedge clk_100MHZ);
    #2 reset = 1'b1;
    #1;
    chk("areset_time", tv(), 16'h0000);
    chk("areset_mode", 16'(mode), 16'h0);
    chk("areset_mask", 16'(edit_mask), 16'h0);
    @(negedge clk_100MHZ) reset = 1'b0;
    repeat (10) @(negedge clk_100MHZ);
    chk("held_after_reset", 16'(mode), 16'h1);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk_100MHZ);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
